spi_slave_regfile: RTL and testbench
====================================

// Module: spi_slave_regfile
// PURPOSE
//  SPI mode-0 slave holding NREG registers of DW bits, oversampled by the system clock clk.
//  A frame carries a device-address header with a R/W bit, a register index, then data words.
//  Supports both read (MISO) and write.
//  Writes update the register file and raise a valid/ack strobe to downstream logic.
//  Sits between the board SPI master and the control registers of the FPGA datapath.
// PARAMETERS
//  DW       8      data word width, bits (2..32)
//  NREG     4      number of registers (1..256)
//  DEV_ADR  7'h01  device address matched against header bits [6:0]
//  RST_VAL  0      reset value loaded into every register
// PORTS
//  clk      in   1        system clock; must be >= 8x sclk
//  rst      in   1        synchronous, active-high reset
//  sclk     in   1        SPI clock, asynchronous to clk, CPOL=0
//  cs       in   1        chip select, active low, asynchronous
//  mosi     in   1        master data, MSB first
//  miso     out  1        slave data; 1 when not driving read data
//  regs_out out  NREG*DW  flat register file; reg k is at [k*DW +: DW]
//  wr_vld   out  1        write event pending
//  wr_idx   out  8        index of last written register
//  wr_data  out  DW       value of last written register
//  wr_ack   in   1        consumer accepts the pending write event
//  ovr      out  1        sticky: a write completed while wr_vld was still high
// BEHAVIOUR
//  - Synchronisation: sclk, cs and mosi each pass through 3 flops; edges are taken on stages 2/3.
//    Delay from a pin edge to the internal edge is 2-3 clk.
//  - Reset: regs=RST_VAL, miso=1, wr_vld=0, wr_idx=0, wr_data=0, ovr=0, state=IDLE.
//  - States: IDLE, HDR, IDX, DATA, SKIP. A cs falling edge from any state -> HDR, bit_cnt=0.
//    A cs rising edge from any state -> IDLE; a partial word is discarded with no write.
//  - HDR: shift mosi on 8 sclk rising edges. Header bit7=1 means write, 0 means read.
//    If bits[6:0]==DEV_ADR go to IDX, else go to SKIP.
//    SKIP ignores all edges and holds miso=1 until cs rises.
//  - IDX: shift 8 bits into idx. On the 8th rising edge go to DATA.
//    For a read, load shreg=reg[idx], or all-ones if idx>=NREG; miso=shreg[DW-1] from the next clk.
//  - DATA write: after DW rising edges, reg[idx]<=word on the following clk.
//    In the same clk: wr_idx=idx, wr_data=word, wr_vld=1. If wr_vld was already 1 and not acked, set ovr=1.
//    idx>=NREG: no register update and no wr_vld.
//  - DATA read: on each sclk falling edge in DATA, shreg shifts left and miso follows shreg[DW-1].
//    After DW rising edges the word is done.
//  - wr_vld stays high until a clk with wr_ack=1, then clears next clk.
//    When a write completion and wr_ack coincide, the new event wins and wr_vld stays 1.
//  - miso=1 in IDLE, HDR, IDX, SKIP and after the final read word.
//  - Reset mid-frame: reset wins; the frame is abandoned and the block is in IDLE until the next cs fall.
// CONFIGURATION
//  SPI_REGFILE_BURST_EN defined:
//    - At each word end idx increments, wrapping from NREG-1 to 0, and DATA continues.
//    - Reads reload shreg from the new idx on the word-end clk.
//  SPI_REGFILE_BURST_EN undefined:
//    - After one word, DATA -> SKIP; further clocks have no effect and miso=1.
// STRUCTURE
//  Package spi_regfile_pkg:
//    - State encoding (IDLE, HDR, IDX, DATA, SKIP).
//    - HDR_RW_BIT=7, HDR_ADR_MSB=6, SYNC_STAGES=3.
//  Sub-module spi_edge_sync: 3-flop synchroniser with rise/fall outputs; one instance each for sclk, cs, mosi.
//  The top holds the FSM, bit counter, shift registers, register file and write handshake.
// TESTING
//  1 Write hdr 8'h81, idx 8'h02, data 8'hA5 -> reg2=A5; wr_vld=1, wr_idx=2, wr_data=A5 until wr_ack.
//  2 Read hdr 8'h01, idx 8'h02 after test 1 -> miso shifts out A5 MSB first; all other registers at RST_VAL.
//  3 Header 8'h85 (address mismatch) followed by 16 clocks -> no register change, miso held 1, wr_vld=0.
//  4 Burst (macro on): write idx 3, data 11,22 -> reg3=11, reg0=22 (wrap).
//    Macro off: reg3=11 only; second word ignored.
//  5 Two writes with no wr_ack in between -> ovr=1, wr_data=second value; rst clears ovr.
//  6 cs raised after 5 data bits, then rst asserted mid-header -> no write; next frame decodes correctly.

Source files
------------

// File: rtl/spi_regfile_pkg.sv
// Shared types and constants for the SPI slave register file.
package spi_regfile_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StIdx,
        StData,
        StSkip
    } spi_state_e;

    localparam int unsigned HDR_RW_BIT  = 7;
    localparam int unsigned HDR_ADR_MSB = 6;
    localparam int unsigned SYNC_STAGES = 3;

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchroniser for an asynchronous pin, with level and edge strobes
// taken from the last two stages.
module spi_edge_sync
    import spi_regfile_pkg::*;
#(
    parameter logic RstVal = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RstVal}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign lvl_o  = sync_q[SYNC_STAGES-2];
    assign rise_o = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
    assign fall_o = ~sync_q[SYNC_STAGES-2] & sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 slave with a small register file and a write-event handshake.
// Define SPI_REGFILE_BURST_EN to stream consecutive words to incrementing indices.
module spi_slave_regfile
    import spi_regfile_pkg::*;
#(
    parameter int unsigned DW      = 8,
    parameter int unsigned NREG    = 4,
    parameter logic [6:0]  DEV_ADR = 7'h01,
    parameter logic [31:0] RST_VAL = 32'h0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sclk_i,
    input  logic                 cs_i,
    input  logic                 mosi_i,
    output logic                 miso_o,
    output logic [NREG*DW-1:0]   regs_out_o,
    output logic                 wr_vld_o,
    output logic [7:0]           wr_idx_o,
    output logic [DW-1:0]        wr_data_o,
    input  logic                 wr_ack_i,
    output logic                 ovr_o
);

    localparam int unsigned IW = (NREG > 1) ? $clog2(NREG) : 1;

    logic sclk_rise, sclk_fall, sclk_lvl;
    logic cs_rise, cs_fall, cs_lvl;
    logic mosi_lvl, mosi_rise, mosi_fall;

    spi_edge_sync #(.RstVal(1'b0)) u_sync_sclk (
        .clk    (clk),
        .rst    (rst),
        .d_i    (sclk_i),
        .lvl_o  (sclk_lvl),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    spi_edge_sync #(.RstVal(1'b1)) u_sync_cs (
        .clk    (clk),
        .rst    (rst),
        .d_i    (cs_i),
        .lvl_o  (cs_lvl),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    spi_edge_sync #(.RstVal(1'b0)) u_sync_mosi (
        .clk    (clk),
        .rst    (rst),
        .d_i    (mosi_i),
        .lvl_o  (mosi_lvl),
        .rise_o (mosi_rise),
        .fall_o (mosi_fall)
    );

    spi_state_e      state_q, state_d;
    logic [5:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      in_q, in_d;
    logic            rw_q, rw_d;
    logic [7:0]      idx_q, idx_d;
    logic [DW-1:0]   word_q, word_d;
    logic [DW-1:0]   shreg_q, shreg_d;
    logic [DW-1:0]   regs_q [NREG];
    logic            wr_en;

    logic            wr_vld_q, wr_vld_d;
    logic [7:0]      wr_idx_q, wr_idx_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;
    logic            ovr_q, ovr_d;

    logic [7:0]      in_full;
    logic [DW-1:0]   word_full;

    assign in_full   = {in_q[6:0], mosi_lvl};
    assign word_full = {word_q[DW-2:0], mosi_lvl};

    function automatic logic idx_ok(input logic [7:0] i);
        return 32'(i) < NREG;
    endfunction

    // Out-of-range indices read as all-ones.
    function automatic logic [DW-1:0] rd_word(input logic [7:0] i);
        if (idx_ok(i)) begin
            return regs_q[i[IW-1:0]];
        end
        return '1;
    endfunction

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        in_d      = in_q;
        rw_d      = rw_q;
        idx_d     = idx_q;
        word_d    = word_q;
        shreg_d   = shreg_q;
        wr_en     = 1'b0;

        if (cs_fall) begin
            state_d   = StHdr;
            bit_cnt_d = '0;
        end else if (cs_rise) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StHdr: begin
                    if (sclk_rise) begin
                        in_d = in_full;
                        if (bit_cnt_q == 6'd7) begin
                            bit_cnt_d = '0;
                            rw_d      = in_full[HDR_RW_BIT];
                            state_d   = (in_full[HDR_ADR_MSB:0] == DEV_ADR) ? StIdx : StSkip;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 6'd1;
                        end
                    end
                end
                StIdx: begin
                    if (sclk_rise) begin
                        in_d = in_full;
                        if (bit_cnt_q == 6'd7) begin
                            bit_cnt_d = '0;
                            idx_d     = in_full;
                            shreg_d   = rd_word(in_full);
                            state_d   = StData;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 6'd1;
                        end
                    end
                end
                StData: begin
                    // The fall that opens a word must not shift: the MSB is sampled on its rise.
                    if (sclk_fall && bit_cnt_q != '0) begin
                        shreg_d = {shreg_q[DW-2:0], 1'b1};
                    end
                    if (sclk_rise) begin
                        word_d = word_full;
                        if (bit_cnt_q == 6'(DW - 1)) begin
                            bit_cnt_d = '0;
                            wr_en     = rw_q && idx_ok(idx_q);
`ifdef SPI_REGFILE_BURST_EN
                            idx_d   = (idx_q == 8'(NREG - 1)) ? 8'd0 : idx_q + 8'd1;
                            shreg_d = rd_word(idx_d);
`else
                            state_d = StSkip;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + 6'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        wr_vld_d  = wr_vld_q;
        wr_idx_d  = wr_idx_q;
        wr_data_d = wr_data_q;
        ovr_d     = ovr_q;
        if (wr_en) begin
            wr_vld_d  = 1'b1;
            wr_idx_d  = idx_q;
            wr_data_d = word_full;
            if (wr_vld_q && !wr_ack_i) begin
                ovr_d = 1'b1;
            end
        end else if (wr_ack_i) begin
            wr_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            in_q      <= '0;
            rw_q      <= 1'b0;
            idx_q     <= '0;
            word_q    <= '0;
            shreg_q   <= '1;
            wr_vld_q  <= 1'b0;
            wr_idx_q  <= '0;
            wr_data_q <= '0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            in_q      <= in_d;
            rw_q      <= rw_d;
            idx_q     <= idx_d;
            word_q    <= word_d;
            shreg_q   <= shreg_d;
            wr_vld_q  <= wr_vld_d;
            wr_idx_q  <= wr_idx_d;
            wr_data_q <= wr_data_d;
            ovr_q     <= ovr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(NREG); k++) begin
                regs_q[k] <= RST_VAL[DW-1:0];
            end
        end else if (wr_en) begin
            regs_q[idx_q[IW-1:0]] <= word_full;
        end
    end

    for (genvar k = 0; k < int'(NREG); k++) begin : g_regs_out
        assign regs_out_o[k*DW +: DW] = regs_q[k];
    end

    assign miso_o    = (state_q == StData && !rw_q) ? shreg_q[DW-1] : 1'b1;
    assign wr_vld_o  = wr_vld_q;
    assign wr_idx_o  = wr_idx_q;
    assign wr_data_o = wr_data_q;
    assign ovr_o     = ovr_q;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed self-checking bench for spi_slave_regfile (DW=8, NREG=4, DEV_ADR=1).
module tb_spi_slave_regfile;

    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk, cs, mosi, miso;
    logic [31:0] regs_out;
    logic        wr_vld, wr_ack, ovr;
    logic [7:0]  wr_idx, wr_data;
    logic [7:0]  rx;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spi_slave_regfile #(
        .DW      (8),
        .NREG    (4),
        .DEV_ADR (7'h01),
        .RST_VAL (32'h0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sclk_i     (sclk),
        .cs_i       (cs),
        .mosi_i     (mosi),
        .miso_o     (miso),
        .regs_out_o (regs_out),
        .wr_vld_o   (wr_vld),
        .wr_idx_o   (wr_idx),
        .wr_data_o  (wr_data),
        .wr_ack_i   (wr_ack),
        .ovr_o      (ovr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx_o);
        rx_o = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            repeat (HALF) @(negedge clk);
            rx_o = {rx_o[6:0], miso};
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_low();
        cs = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (HALF) @(negedge clk);
        cs = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic write_frame(input logic [7:0] idx, input logic [7:0] data);
        cs_low();
        spi_xfer(8'h81, 8, rx);
        spi_xfer(idx, 8, rx);
        spi_xfer(data, 8, rx);
        cs_high();
    endtask

    task automatic ack_pulse();
        wr_ack = 1'b1;
        @(negedge clk);
        wr_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0; wr_ack = 1'b0;
        @(negedge clk);
        do_reset();
        check("rst_regs", regs_out, 32'h0);
        check("rst_miso", {31'b0, miso}, 32'h1);
        check("rst_vld", {31'b0, wr_vld}, 32'h0);
        check("rst_widx", {24'b0, wr_idx}, 32'h0);
        check("rst_wdata", {24'b0, wr_data}, 32'h0);
        check("rst_ovr", {31'b0, ovr}, 32'h0);

        // Single write to reg2
        write_frame(8'h02, 8'hA5);
        check("t1_reg2", {24'b0, regs_out[23:16]}, 32'hA5);
        check("t1_vld", {31'b0, wr_vld}, 32'h1);
        check("t1_widx", {24'b0, wr_idx}, 32'h2);
        check("t1_wdata", {24'b0, wr_data}, 32'hA5);
        repeat (10) @(negedge clk);
        check("t1_vld_hold", {31'b0, wr_vld}, 32'h1);
        ack_pulse();
        check("t1_vld_acked", {31'b0, wr_vld}, 32'h0);
        check("t1_ovr", {31'b0, ovr}, 32'h0);

        // Read reg2 back
        cs_low();
        spi_xfer(8'h01, 8, rx);
        spi_xfer(8'h02, 8, rx);
        spi_xfer(8'h00, 8, rx);
        check("t2_rx", {24'b0, rx}, 32'hA5);
`ifndef SPI_REGFILE_BURST_EN
        check("t2_miso_end", {31'b0, miso}, 32'h1);
`endif
        cs_high();
        check("t2_regs", regs_out, 32'h00A5_0000);
        check("t2_vld", {31'b0, wr_vld}, 32'h0);

        // Address mismatch, then 16 more clocks
        cs_low();
        spi_xfer(8'h85, 8, rx);
        spi_xfer(8'h02, 8, rx);
        check("t3_miso_a", {24'b0, rx}, 32'hFF);
        spi_xfer(8'h3C, 8, rx);
        check("t3_miso_b", {24'b0, rx}, 32'hFF);
        cs_high();
        check("t3_regs", regs_out, 32'h00A5_0000);
        check("t3_vld", {31'b0, wr_vld}, 32'h0);

        // Two-word frame at idx3
        cs_low();
        spi_xfer(8'h81, 8, rx);
        spi_xfer(8'h03, 8, rx);
        spi_xfer(8'h11, 8, rx);
        spi_xfer(8'h22, 8, rx);
        cs_high();
        check("t4_reg3", {24'b0, regs_out[31:24]}, 32'h11);
`ifdef SPI_REGFILE_BURST_EN
        check("t4_reg0", {24'b0, regs_out[7:0]}, 32'h22);
        check("t4_wdata", {24'b0, wr_data}, 32'h22);
        check("t4_widx", {24'b0, wr_idx}, 32'h0);
        check("t4_ovr", {31'b0, ovr}, 32'h1);
`else
        check("t4_reg0", {24'b0, regs_out[7:0]}, 32'h00);
        check("t4_wdata", {24'b0, wr_data}, 32'h11);
        check("t4_widx", {24'b0, wr_idx}, 32'h3);
        check("t4_ovr", {31'b0, ovr}, 32'h0);
`endif
        ack_pulse();
        do_reset();
        check("t4_rst_regs", regs_out, 32'h0);

        // Overrun: two writes without ack
        write_frame(8'h01, 8'h5A);
        check("t5_ovr_first", {31'b0, ovr}, 32'h0);
        write_frame(8'h01, 8'hC3);
        check("t5_ovr", {31'b0, ovr}, 32'h1);
        check("t5_wdata", {24'b0, wr_data}, 32'hC3);
        check("t5_reg1", {24'b0, regs_out[15:8]}, 32'hC3);
        do_reset();
        check("t5_ovr_rst", {31'b0, ovr}, 32'h0);
        check("t5_vld_rst", {31'b0, wr_vld}, 32'h0);

        // Abandoned frame, then reset mid-header, then a clean frame
        cs_low();
        spi_xfer(8'h81, 8, rx);
        spi_xfer(8'h00, 8, rx);
        spi_xfer(8'hF0, 5, rx);
        cs_high();
        check("t6_no_write", regs_out, 32'h0);
        check("t6_no_vld", {31'b0, wr_vld}, 32'h0);
        cs_low();
        spi_xfer(8'h81, 4, rx);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        cs = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("t6_rst_vld", {31'b0, wr_vld}, 32'h0);
        write_frame(8'h00, 8'h3C);
        check("t6_reg0", {24'b0, regs_out[7:0]}, 32'h3C);
        check("t6_vld", {31'b0, wr_vld}, 32'h1);
        check("t6_widx", {24'b0, wr_idx}, 32'h0);
        cs_low();
        spi_xfer(8'h01, 8, rx);
        spi_xfer(8'h00, 8, rx);
        spi_xfer(8'h00, 8, rx);
        cs_high();
        check("t6_rx", {24'b0, rx}, 32'h3C);

        // Out-of-range index: all-ones read, no write
        ack_pulse();
        write_frame(8'h07, 8'h99);
        check("t7_no_vld", {31'b0, wr_vld}, 32'h0);
        check("t7_regs", regs_out, 32'h0000_003C);
        cs_low();
        spi_xfer(8'h01, 8, rx);
        spi_xfer(8'h09, 8, rx);
        spi_xfer(8'h00, 8, rx);
        cs_high();
        check("t7_rx", {24'b0, rx}, 32'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
